// File: rtl/timer_chain.sv
// Cascadable modulo down/up counter chain: DIGITS stages, each with its own
// maximum, borrow/carry rippling combinationally across all stages per cycle.
module timer_chain_digit #(
   parameter int              WIDTH = 4,
   parameter logic [WIDTH-1:0] MAXV = '1
) (
   input  logic             clk,
   input  logic             clrn,
   input  logic             load,
   input  logic [WIDTH-1:0] ldv,
   input  logic             step,
   input  logic             up,
   output logic [WIDTH-1:0] q,
   output logic             tc,
   output logic             lo,
   output logic             hi
);
   assign lo = (q == '0);
   assign hi = (q == MAXV);

   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         q  <= '0;
         tc <= 1'b0;
      end else if (load) begin
         q  <= (ldv > MAXV) ? MAXV : ldv;
         tc <= 1'b0;
      end else if (step) begin
         if (up) begin
            q  <= hi ? '0 : q + WIDTH'(1);
            tc <= hi;
         end else begin
            q  <= lo ? MAXV : q - WIDTH'(1);
            tc <= lo;
         end
      end else begin
         tc <= 1'b0;
      end
   end
endmodule

module timer_chain #(
   parameter int                     DIGITS       = 4,
   parameter int                     WIDTH        = 4,
   parameter logic [DIGITS*WIDTH-1:0] MAXV        = 16'h5959,
   parameter bit                     STOP_AT_ZERO = 1'b1
) (
   input  logic                    clk,
   input  logic                    clrn,
   input  logic                    loadn,
   input  logic [DIGITS*WIDTH-1:0] data,
   input  logic                    en,
   input  logic                    up,
   output logic [DIGITS*WIDTH-1:0] out,
   output logic [DIGITS-1:0]       tc,
   output logic                    zero,
   output logic                    done
);
   logic [DIGITS-1:0][WIDTH-1:0] q, din;
   logic [DIGITS-1:0]            lo, hi, step;
   logic                         go, bor, car, last;

   assign din  = data;
   assign out  = q;
   assign zero = (out == '0);

   // An all-zero down-count freezes the whole chain when stopping at zero.
   assign go = en & ~(~up & zero & STOP_AT_ZERO);

   always_comb begin
      bor  = go;
      car  = go;
      step = '0;
      for (int i = 0; i < DIGITS; i++) begin
         step[i] = up ? car : bor;
         bor     = bor & lo[i];
         car     = car & hi[i];
      end
   end

   // Only a count of exactly 1 reaches zero on the next down-step.
   assign last = (out[WIDTH-1:0] == WIDTH'(1)) && ((out >> WIDTH) == '0);

   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) done <= 1'b0;
      else       done <= loadn & go & ~up & last;
   end

   for (genvar i = 0; i < DIGITS; i++) begin : g_dig
      timer_chain_digit #(
         .WIDTH(WIDTH),
         .MAXV (MAXV[i*WIDTH +: WIDTH])
      ) u_dig (
         .clk (clk),
         .clrn(clrn),
         .load(~loadn),
         .ldv (din[i]),
         .step(step[i]),
         .up  (up),
         .q   (q[i]),
         .tc  (tc[i]),
         .lo  (lo[i]),
         .hi  (hi[i])
      );
   end
endmodule

// File: tb/tb_timer_chain.sv
// Directed bench for timer_chain: a stop-at-zero and a wrapping instance
// share one stimulus stream.
module tb_timer_chain;
   logic        clk = 1'b0, clrn = 1'b0, loadn = 1'b1, en = 1'b0, up = 1'b0;
   logic [15:0] data = '0;
   logic [15:0] out_a, out_b;
   logic [3:0]  tc_a, tc_b;
   logic        zero_a, zero_b, done_a, done_b;
   int          checks = 0, errors = 0;

   always #5 clk = ~clk;

   timer_chain #(.STOP_AT_ZERO(1'b1)) dut_a (
      .clk(clk), .clrn(clrn), .loadn(loadn), .data(data), .en(en), .up(up),
      .out(out_a), .tc(tc_a), .zero(zero_a), .done(done_a));

   timer_chain #(.STOP_AT_ZERO(1'b0)) dut_b (
      .clk(clk), .clrn(clrn), .loadn(loadn), .data(data), .en(en), .up(up),
      .out(out_b), .tc(tc_b), .zero(zero_b), .done(done_b));

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic do_load(input logic [15:0] v);
      loadn = 1'b0; en = 1'b0; data = v;
      tick();
      loadn = 1'b1;
   endtask

   task automatic do_step(input logic dir);
      en = 1'b1; up = dir;
      tick();
      en = 1'b0;
   endtask

   task automatic test_reset();
      #3;
      checks++; if (out_a !== 16'h0 || tc_a !== 4'h0 || done_a !== 1'b0 || zero_a !== 1'b1) begin
         errors++; $display("FAIL reset_init: out=%h tc=%b done=%b zero=%b expected 0000/0000/0/1", out_a, tc_a, done_a, zero_a); end
      tick(); clrn = 1'b1; tick();
      do_load(16'h0124);
      do_step(1'b0);
      checks++; if (out_a !== 16'h0123) begin
         errors++; $display("FAIL reset_precount: out=%h expected 0123", out_a); end
      en = 1'b1; #2; clrn = 1'b0; #1;
      checks++; if (out_a !== 16'h0 || tc_a !== 4'h0 || done_a !== 1'b0 || zero_a !== 1'b1) begin
         errors++; $display("FAIL reset_midcount: out=%h tc=%b done=%b zero=%b expected 0000/0000/0/1", out_a, tc_a, done_a, zero_a); end
      en = 1'b0; tick(); clrn = 1'b1; tick();
      // done pulse in flight is cleared by reset
      do_load(16'h0001);
      do_step(1'b0);
      checks++; if (done_a !== 1'b1) begin
         errors++; $display("FAIL reset_done_setup: done=%b expected 1", done_a); end
      #2; clrn = 1'b0; #1;
      checks++; if (done_a !== 1'b0 || out_a !== 16'h0) begin
         errors++; $display("FAIL reset_done_clear: done=%b out=%h expected 0/0000", done_a, out_a); end
      tick(); clrn = 1'b1; tick();
   endtask

   task automatic test_borrow();
      do_load(16'h0100);
      do_step(1'b0);
      checks++; if (out_a !== 16'h0059 || tc_a !== 4'b0011 || done_a !== 1'b0) begin
         errors++; $display("FAIL borrow: out=%h tc=%b done=%b expected 0059/0011/0", out_a, tc_a, done_a); end
   endtask

   task automatic test_stop_zero();
      do_load(16'h0001);
      do_step(1'b0);
      checks++; if (out_a !== 16'h0 || done_a !== 1'b1 || zero_a !== 1'b1 || tc_a !== 4'h0) begin
         errors++; $display("FAIL stop_first: out=%h done=%b zero=%b tc=%b expected 0000/1/1/0000", out_a, done_a, zero_a, tc_a); end
      checks++; if (out_b !== 16'h0 || done_b !== 1'b1 || zero_b !== 1'b1) begin
         errors++; $display("FAIL wrap_first: out=%h done=%b zero=%b expected 0000/1/1", out_b, done_b, zero_b); end
      do_step(1'b0);
      checks++; if (out_a !== 16'h0 || done_a !== 1'b0 || tc_a !== 4'h0) begin
         errors++; $display("FAIL stop_hold: out=%h done=%b tc=%b expected 0000/0/0000", out_a, done_a, tc_a); end
      checks++; if (out_b !== 16'h5959 || tc_b !== 4'b1111 || done_b !== 1'b0 || zero_b !== 1'b0) begin
         errors++; $display("FAIL wrap_max: out=%h tc=%b done=%b zero=%b expected 5959/1111/0/0", out_b, tc_b, done_b, zero_b); end
   endtask

   task automatic test_load_sat();
      do_load(16'h0042);
      loadn = 1'b0; en = 1'b1; up = 1'b0; data = 16'h7A3F;
      tick();
      loadn = 1'b1; en = 1'b0;
      checks++; if (out_a !== 16'h5939 || tc_a !== 4'h0 || done_a !== 1'b0) begin
         errors++; $display("FAIL load_sat: out=%h tc=%b done=%b expected 5939/0000/0", out_a, tc_a, done_a); end
   endtask

   task automatic test_up_wrap();
      do_load(16'h5959);
      do_step(1'b1);
      checks++; if (out_a !== 16'h0 || tc_a !== 4'b1111 || done_a !== 1'b0 || zero_a !== 1'b1) begin
         errors++; $display("FAIL up_wrap: out=%h tc=%b done=%b zero=%b expected 0000/1111/0/1", out_a, tc_a, done_a, zero_a); end
      do_load(16'h0009);
      do_step(1'b1);
      checks++; if (out_a !== 16'h0010 || tc_a !== 4'b0001) begin
         errors++; $display("FAIL up_carry: out=%h tc=%b expected 0010/0001", out_a, tc_a); end
   endtask

   task automatic test_enable();
      do_load(16'h0030);
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++; if (out_a !== 16'h0030 || tc_a !== 4'h0) begin
            errors++; $display("FAIL en_hold[%0d]: out=%h tc=%b expected 0030/0000", i, out_a, tc_a); end
      end
      do_step(1'b0);
      checks++; if (out_a !== 16'h0029 || tc_a !== 4'b0001) begin
         errors++; $display("FAIL en_step: out=%h tc=%b expected 0029/0001", out_a, tc_a); end
   endtask

   task automatic test_back_to_back();
      do_load(16'h0002);
      en = 1'b1; up = 1'b0;
      tick();
      checks++; if (out_a !== 16'h0001 || done_a !== 1'b0 || zero_a !== 1'b0) begin
         errors++; $display("FAIL b2b_one: out=%h done=%b zero=%b expected 0001/0/0", out_a, done_a, zero_a); end
      tick();
      checks++; if (out_a !== 16'h0 || done_a !== 1'b1) begin
         errors++; $display("FAIL b2b_zero: out=%h done=%b expected 0000/1", out_a, done_a); end
      en = 1'b0;
      tick();
      checks++; if (done_a !== 1'b0 || tc_a !== 4'h0 || out_a !== 16'h0) begin
         errors++; $display("FAIL b2b_pulse: done=%b tc=%b out=%h expected 0/0000/0000", done_a, tc_a, out_a); end
      do_load(16'h0910);
      do_step(1'b0);
      checks++; if (out_a !== 16'h0909 || tc_a !== 4'b0001) begin
         errors++; $display("FAIL b2b_mid: out=%h tc=%b expected 0909/0001", out_a, tc_a); end
   endtask

   initial begin
      test_reset();
      test_borrow();
      test_stop_zero();
      test_load_sat();
      test_up_wrap();
      test_enable();
      test_back_to_back();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
